// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int BE_W       = DEF_DATA_W / 8;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Replace the byte lanes selected by be with the lanes of new_w.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset sweep sequencer: walks every entry once, then hands over to RUN.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy_o,
    output logic              run_o,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o
);

    // One bit wider than the address so a full 2**ADDR_W sweep cannot wrap.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // State and sweep counter registers; rst restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Advance one entry per cycle while sweeping; leave INIT after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
                state_d = RUN;
            end
        end
    end

    assign busy_o      = (state_q == INIT);
    // A reset arriving while in RUN must kill any concurrent access.
    assign run_o       = (state_q == RUN) && !rst;
    assign init_we_o   = (state_q == INIT) && !rst;
    assign init_addr_o = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/regfile_multiport.sv
// Register file: two registered read ports, one byte-enabled write port,
// optional write-to-read bypass and optional hardwired-zero entry 0.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int DBG_IDX  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                busy,
    output logic [DATA_W-1:0]   dbg_data
);

    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;

    logic              run;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              wr_acc;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_val_a, rd_val_b;

    regfile_init_seq #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .busy_o      (busy),
        .run_o       (run),
        .init_we_o   (init_we),
        .init_addr_o (init_addr)
    );

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_W);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_acc    = run && wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
    assign wr_old    = in_range(wr_addr) ? mem_q[wr_addr] : '0;
    assign wr_merged = DATA_W'(merge_bytes(MAX_DATA_W'(wr_old), MAX_DATA_W'(wr_data),
                                           MAX_BE_W'(wr_be)));

    // Value a read port captures this edge, including same-address forwarding.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (in_range(a) && !is_zero_reg(a)) begin
            v = mem_q[a];
            if ((BYPASS != 0) && wr_acc && (wr_addr == a)) begin
                v = wr_merged;
            end
        end
        return v;
    endfunction

    assign rd_val_a = read_port(rd_addr_a);
    assign rd_val_b = read_port(rd_addr_b);

    // Array update: the sweep's zero writes take priority over the user port.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= '0;
        end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_merged;
        end
    end

    // Read registers: zero outside RUN or when no read is strobed.
    always_ff @(posedge clk) begin
        if (!run || !rd_en) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            rd_data_a_q <= rd_val_a;
            rd_data_b_q <= rd_val_b;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

    generate
        if (DBG_IDX < NUM_REGS) begin : g_dbg
            localparam logic [ADDR_W-1:0] DBG_A = ADDR_W'(DBG_IDX);
            assign dbg_data = mem_q[DBG_A];
        end else begin : g_dbg_none
            assign dbg_data = '0;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with default parameters.
module tb_regfile_multiport;
    import regfile_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_en;
    logic [4:0]      rd_addr_a, rd_addr_b;
    logic [31:0]     rd_data_a, rd_data_b;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_data;
    logic [BE_W-1:0] wr_be;
    logic            busy;
    logic [31:0]     dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    regfile_multiport dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .busy      (busy),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a, input logic [4:0] b);
        rd_en = 1'b1; rd_addr_a = a; rd_addr_b = b;
        tick();
        rd_en = 1'b0;
    endtask

    // Count cycles until busy falls, bounded; reads must stay zero throughout.
    task automatic sweep(input string tag);
        int cnt;
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
            if (busy) chk({tag, "_rd_zero"}, rd_data_a | rd_data_b, 32'h0);
        end
        chk({tag, "_busy_cycles"}, cnt, 32'd32);
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        tick(); tick();
        chk("rst_busy", busy, 1'b1);
        chk("rst_rd_a", rd_data_a, 32'h0);
        chk("rst_rd_b", rd_data_b, 32'h0);

        // Sweep with reads and writes held active; both must be ignored.
        rst = 1'b0;
        rd_en = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        sweep("init");
        wr_en = 1'b0; rd_en = 1'b0;
        chk("init_busy_low", busy, 1'b0);
        chk("init_dbg", dbg_data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd2(5'(i), 5'(31 - i));
            chk($sformatf("init_rd_a_%0d", i), rd_data_a, 32'h0);
            chk($sformatf("init_rd_b_%0d", 31 - i), rd_data_b, 32'h0);
        end

        // Basic write then read.
        wr(5'd4, 32'hAABB_CCEE, 4'hF);
        rd2(5'd4, 5'd0);
        chk("basic_a", rd_data_a, 32'hAABB_CCEE);
        chk("basic_b", rd_data_b, 32'h0);
        tick();
        chk("rden0_a", rd_data_a, 32'h0);
        wr(5'd4, 32'h0, 4'h0);
        rd2(5'd4, 5'd4);
        chk("be0_noop", rd_data_a, 32'hAABB_CCEE);

        // Byte enables and hardwired zero entry.
        wr(5'd5, 32'h1122_3344, 4'hF);
        wr(5'd5, 32'hDDDD_DDDD, 4'b0011);
        rd2(5'd5, 5'd5);
        chk("be_a", rd_data_a, 32'h1122_DDDD);
        chk("be_b", rd_data_b, 32'h1122_DDDD);
        wr(5'd0, 32'hFFFF_FFFF, 4'hF);
        rd2(5'd0, 5'd0);
        chk("zero_reg", rd_data_a, 32'h0);

        // Same-cycle write and read of one address.
        wr(5'd7, 32'h0000_0007, 4'hF);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("byp_a", rd_data_a, 32'h1234_5678);
        chk("byp_b", rd_data_b, 32'h1234_5678);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA_AAAA; wr_be = 4'b0101;
        rd_en = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd4;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("byp_part_a", rd_data_a, 32'h12AA_56AA);
        chk("byp_part_b", rd_data_b, 32'hAABB_CCEE);
        rd2(5'd7, 5'd7);
        chk("after_part", rd_data_a, 32'h12AA_56AA);

        // Reset in RUN with a concurrent write: write lost, sweep clears.
        wr(5'd3, 32'h0000_DEAD, 4'hF);
        chk("dbg_dead", dbg_data, 32'h0000_DEAD);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_BEEF; wr_be = 4'hF;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        chk("mid_rst_busy", busy, 1'b1);
        chk("mid_rst_wr_lost", dbg_data, 32'h0000_DEAD);
        sweep("mid");
        chk("mid_dbg", dbg_data, 32'h0);
        rd2(5'd3, 5'd4);
        chk("mid_rd3", rd_data_a, 32'h0);
        chk("mid_rd4", rd_data_b, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
